// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use hazard detection and registered EX operand forwarding selects
// Optional stall performance counter is built when HAZ_STALL_CNT_EN is defined.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    // Selects are resolved one edge early, so only the EX and MEM slots are consulted;
    // whatever sits in WB has already been written back by the time ID reaches EX.
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
    logic              ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, mem_wr_q, mem_wr_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic              haz;
    logic              ex_prod, mem_prod;

    always_comb begin
        ex_prod  = ex_wr_q && (ex_rd_q != '0);
        mem_prod = mem_wr_q && (mem_rd_q != '0);
        haz      = ex_ld_q && ex_prod &&
                   ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                    (id_rs2_used && (id_rs2 == ex_rd_q)));
        stall    = haz && !flush;
        bubble   = haz || flush;
    end

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!bubble) begin
            // A load in EX never reaches here with a matching reader: that case bubbles.
            if (ex_prod && !ex_ld_q && id_rs1_used && (id_rs1 == ex_rd_q))
                fwd_a_d = 2'b10;
            else if (mem_prod && id_rs1_used && (id_rs1 == mem_rd_q))
                fwd_a_d = 2'b01;
            if (ex_prod && !ex_ld_q && id_rs2_used && (id_rs2 == ex_rd_q))
                fwd_b_d = 2'b10;
            else if (mem_prod && id_rs2_used && (id_rs2 == mem_rd_q))
                fwd_b_d = 2'b01;
        end
    end

    always_comb begin
        mem_rd_d = ex_rd_q;
        mem_wr_d = ex_wr_q;
        ex_rd_d  = id_rd;
        ex_wr_d  = id_regwrite;
        ex_ld_d  = id_memread;
        if (bubble) begin
            ex_rd_d = '0;
            ex_wr_d = 1'b0;
            ex_ld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd_q  <= '0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_wr_q <= 1'b0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
        end else begin
            ex_rd_q  <= ex_rd_d;
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit with directed instruction vectors
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_regwrite, id_memread, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, bubble;
    logic [31:0] stall_count;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        bu;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_m    = 0;
    int   tag      = 0;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    always begin
        @(negedge clk or posedge rst);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("fwd_a", e.tag, 32'(fwd_a), 32'(e.fa));
            check("fwd_b", e.tag, 32'(fwd_b), 32'(e.fb));
            check("stall", e.tag, 32'(stall), 32'(e.st));
            check("bubble", e.tag, 32'(bubble), 32'(e.bu));
            check("stall_count", e.tag, stall_count, e.cnt);
        end
    end

    task automatic push_exp(input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic bu);
        exp_t e;
        e.tag = tag;
        e.fa  = fa;
        e.fb  = fb;
        e.st  = st;
        e.bu  = bu;
`ifdef HAZ_STALL_CNT_EN
        e.cnt = 32'(cnt_m);
`else
        e.cnt = 32'd0;
`endif
        q.push_back(e);
        if (st) cnt_m++;
        tag++;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic wr, input logic ld, input logic fl);
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_regwrite = wr;
        id_memread  = ld;
        flush       = fl;
    endtask

    // One ID-stage cycle; the expectations are what the DUT shows during that same cycle.
    task automatic step(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic wr, input logic ld, input logic fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic st, input logic bu);
        @(posedge clk);
        #1;
        drive(rd, rs1, rs2, u1, u2, wr, ld, fl);
        push_exp(fa, fb, st, bu);
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        push_exp(2'b00, 2'b00, 1'b0, 1'b1);          // bubble follows flush in reset
        @(posedge clk);
        #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        //    rd    rs1   rs2   u1 u2 wr ld fl   fa     fb     st bu
        step(5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x3,x1,x2
        step(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5,x1,x2
        step(5'd6, 5'd5, 5'd7, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // sub x6,x5,x7
        step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0); // nop; sub in EX
        step(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
        step(5'd10, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x10 (unrelated)
        step(5'd8, 5'd7, 5'd5, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // or x8,x7,x5
        step(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b01, 0, 0); // add x5; or in EX
        step(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5 again
        step(5'd8, 5'd7, 5'd5, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // or x8,x7,x5
        step(5'd4, 5'd1, 5'd0, 1, 0, 1, 1, 0, 2'b00, 2'b10, 0, 0); // lw x4; or in EX
        step(5'd9, 5'd4, 5'd4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1); // add x9,x4,x4 load-use
        step(5'd9, 5'd4, 5'd4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // held add
        step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0); // nop; add in EX
        step(5'd4, 5'd1, 5'd0, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0); // lw x4
        step(5'd9, 5'd4, 5'd4, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1); // hazard + flush
        step(5'd11, 5'd4, 5'd4, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x11,x4,x4
        step(5'd0, 5'd1, 5'd0, 1, 0, 1, 0, 0, 2'b01, 2'b01, 0, 0); // addi x0,x1
        step(5'd12, 5'd0, 5'd0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x12,x0,x0
        step(5'd0, 5'd1, 5'd0, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0); // lw x0
        step(5'd13, 5'd0, 5'd0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x13,x0,x0
        step(5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0); // add x5
        step(5'd4, 5'd5, 5'd0, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0); // lw x4,0(x5)
        step(5'd9, 5'd4, 5'd5, 1, 1, 1, 0, 0, 2'b10, 2'b00, 1, 1); // add x9,x4,x5

        // Mid-cycle asynchronous reset while the load and its consumer are in flight.
        @(negedge clk);
        #3;
        cnt_m = 0;
        push_exp(2'b00, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_exp(2'b00, 2'b00, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step(5'd9, 5'd4, 5'd5, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
